l1d_cache_dm: RTL and testbench
===============================

// Module: l1d_cache_dm
// PURPOSE
//  Parametrised direct-mapped L1 data cache between the core LSU and L2.
//  Read-allocate, write-through, no-write-allocate, one word per line, byte strobes.
//  Per-set valid bits are held in flops, with a single-cycle flush.
//  Valid/ready handshake on both sides; one outstanding request at a time.
// PARAMETERS
//  ADDR_W  32  byte-address width
//  DATA_W  32  word width; multiple of 8
//  SET_W   6   index bits; SETS = 2**SET_W
//  OFF_W   log2(DATA_W/8), derived; TAG_W = ADDR_W-SET_W-OFF_W, derived
// PORTS
//  clk            in   1         clock
//  rst_n          in   1         reset, asynchronous, active-low
//  cpu_req_valid  in   1         core request
//  cpu_req_ready  out  1         request accepted when valid&ready
//  cpu_we         in   1         1=store, 0=load
//  cpu_addr       in   ADDR_W    byte address; low OFF_W bits ignored
//  cpu_wdata      in   DATA_W    store data
//  cpu_wstrb      in   DATA_W/8  store byte enables
//  flush_i        in   1         invalidate all lines
//  cpu_rsp_valid  out  1         one-cycle completion pulse (load and store)
//  cpu_rdata      out  DATA_W    load data, valid with cpu_rsp_valid
//  l2_req_valid   out  1         L2 request
//  l2_req_ready   in   1         L2 accepts
//  l2_req_we      out  1         1=write-through, 0=refill read
//  l2_req_addr    out  ADDR_W    word-aligned (low OFF_W bits zero)
//  l2_req_wdata   out  DATA_W    store data
//  l2_req_wstrb   out  DATA_W/8  store strobes
//  l2_rsp_valid   in   1         L2 read data / write ack
//  l2_rsp_data    in   DATA_W    refill data
// BEHAVIOUR
//  Reset: state IDLE; all valid bits 0; every output 0 except cpu_req_ready=1.
//  Reset mid-transaction abandons it; L2 is reset on the same rst_n.
//  Address split: tag | index[SET_W] | offset[OFF_W].
//  Tag/data SRAM: synchronous read, 1-cycle latency, one port.
//  FSM:
//  IDLE: cpu_req_ready=1 iff !flush_i.
//   - flush_i: clear all valid bits this cycle; flush beats a request.
//   - Accept: latch we/addr/wdata/wstrb; read SRAM at index -> LOOKUP.
//  LOOKUP: hit = valid[idx] & (tag_rd == req_tag).
//   - Load hit: cpu_rsp_valid=1, cpu_rdata=data_rd -> IDLE.
//     Latency: accept at N, response at N+1.
//   - Load miss -> MISS_REQ.
//   - Store hit: write byte-merge(data_rd, wdata, wstrb) to data SRAM -> WR_REQ.
//   - Store miss: no SRAM write -> WR_REQ.
//  MISS_REQ: l2_req_valid=1, we=0; leave on l2_req_ready -> MISS_WAIT.
//  MISS_WAIT: on l2_rsp_valid:
//   - write tag, data=l2_rsp_data, valid[idx]=1;
//   - same cycle cpu_rsp_valid=1, cpu_rdata=l2_rsp_data -> IDLE.
//  WR_REQ: l2_req_valid=1, we=1, wdata/wstrb from latch; on l2_req_ready -> WR_WAIT.
//  WR_WAIT: on l2_rsp_valid: cpu_rsp_valid=1 -> IDLE.
//  l2_req_* stay stable while valid & !ready; l2_req_valid drops the cycle after acceptance.
//  l2_rsp_valid outside MISS_WAIT/WR_WAIT is ignored.
//  Responses may arrive the cycle after acceptance; no timeout.
//  cpu_rdata holds its last value when cpu_rsp_valid=0; flush_i outside IDLE is ignored.
//  Index conflict: refill overwrites the line; no write-back is needed (write-through).
// STRUCTURE
//  l1d_pkg: state enum (IDLE, LOOKUP, MISS_REQ, MISS_WAIT, WR_REQ, WR_WAIT);
//    byte-merge function; clog2 helper.
//  Sub-module l1d_sram_sp: parametrised sync-read single-port RAM.
//    Two instances: tag (TAG_W x SETS), data (DATA_W x SETS).
//  Valid vector, FSM and request latch live in the top level.
// TESTING (ADDR_W=32, DATA_W=32, SET_W=6)
//  1. Load 0x40 after reset -> miss; L2 read addr 0x40.
//     L2 returns 0xDEADBEEF -> rsp 0xDEADBEEF. Reload 0x40 -> rsp at N+1, no L2 request.
//  2. Store 0x40 data 0x00001234 strb 0011 (hit) -> L2 write with same data/strb.
//     Reload -> hit, rdata 0xDEAD1234.
//  3. Store to 0x80 (cold) -> L2 write only. Load 0x80 -> miss (no allocate).
//  4. Load 0x140 (same index as 0x40) -> miss and refill. Load 0x40 -> miss again.
//  5. flush_i with cpu_req_valid, same cycle -> ready=0, flush taken.
//     Load 0x40 -> miss.
//  6. l2_req_ready held low 5 cycles -> l2_req_* stable, cpu_req_ready=0.
//     rst_n pulse during MISS_WAIT -> IDLE, outputs reset, load 0x40 misses.

Source files
------------

// File: rtl/l1d_pkg.sv
// l1d_pkg: shared types and helpers for the direct-mapped L1 data cache.
//   state_t    : controller states
//   clog2      : ceiling log2, used for the derived offset width
//   merge_byte : selects the store byte or the old byte under one strobe bit
package l1d_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    MISS_REQ  = 3'd2,
    MISS_WAIT = 3'd3,
    WR_REQ    = 3'd4,
    WR_WAIT   = 3'd5
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 32'd0;
    span   = 32'd1;
    while (span < value) begin
      span   = span << 32'd1;
      result = result + 32'd1;
    end
    return result;
  endfunction

  function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       enable);
    return enable ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/l1d_sram_sp.sv
// l1d_sram_sp: single-port RAM with synchronous read (1-cycle latency).
//   clk   : clock            rst_n : async active-low reset (read register only)
//   en    : port enable      we    : write (1) / read (0)
//   addr  : word index       wdata : write data
//   rdata : read data, valid the cycle after a read access
module l1d_sram_sp #(
  parameter int W  = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [W-1:0] mem [DEPTH];

  // array write port; contents are not reset
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/l1d_cache_dm.sv
// l1d_cache_dm: direct-mapped L1 data cache, read-allocate, write-through,
// no-write-allocate, one word per line, byte strobes, single-cycle flush.
//   cpu_req_* : core request (valid/ready), cpu_rsp_* : completion pulse + load data
//   flush_i   : invalidate every line (only honoured while idle)
//   l2_req_*  : refill read / write-through request to L2 (valid/ready)
//   l2_rsp_*  : refill data or write acknowledge from L2
module l1d_cache_dm
  import l1d_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SET_W  = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req_valid,
  output logic                cpu_req_ready,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_wstrb,
  input  logic                flush_i,
  output logic                cpu_rsp_valid,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                l2_req_valid,
  input  logic                l2_req_ready,
  output logic                l2_req_we,
  output logic [ADDR_W-1:0]   l2_req_addr,
  output logic [DATA_W-1:0]   l2_req_wdata,
  output logic [DATA_W/8-1:0] l2_req_wstrb,
  input  logic                l2_rsp_valid,
  input  logic [DATA_W-1:0]   l2_rsp_data
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = clog2(STRB_W);
  localparam int TAG_W  = ADDR_W - SET_W - OFF_W;
  localparam int SETS   = 2 ** SET_W;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1'b1) << OFF_W) - ADDR_W'(1'b1));

  state_t              state, state_nxt;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [STRB_W-1:0]   req_wstrb;
  logic [SETS-1:0]     valid;
  logic [DATA_W-1:0]   rdata_hold;

  logic [SET_W-1:0]    req_idx, cpu_idx, sram_idx;
  logic [TAG_W-1:0]    req_tag, tag_rd;
  logic [DATA_W-1:0]   data_rd, data_wdata, merged, rsp_data;
  logic                sram_en, tag_we, data_we;
  logic                hit, accept, do_flush, refill, load_rsp;

  // the latched address is already word-aligned, so it feeds L2 directly
  assign req_idx      = req_addr[OFF_W +: SET_W];
  assign req_tag      = req_addr[ADDR_W-1 -: TAG_W];
  assign cpu_idx      = cpu_addr[OFF_W +: SET_W];
  assign hit          = valid[req_idx] && (tag_rd == req_tag);
  assign l2_req_addr  = req_addr;
  assign l2_req_wdata = req_wdata;
  assign l2_req_wstrb = req_wstrb;
  assign cpu_rdata    = load_rsp ? rsp_data : rdata_hold;

  l1d_sram_sp #(.W(TAG_W), .AW(SET_W)) u_tag (
    .clk(clk), .rst_n(rst_n), .en(sram_en), .we(tag_we),
    .addr(sram_idx), .wdata(req_tag), .rdata(tag_rd)
  );

  l1d_sram_sp #(.W(DATA_W), .AW(SET_W)) u_data (
    .clk(clk), .rst_n(rst_n), .en(sram_en), .we(data_we),
    .addr(sram_idx), .wdata(data_wdata), .rdata(data_rd)
  );

  // store-hit byte merge of the stored line with the latched store data
  always_comb begin
    merged = '0;
    for (int b = 0; b < STRB_W; b++) begin
      merged[8*b +: 8] = merge_byte(data_rd[8*b +: 8], req_wdata[8*b +: 8], req_wstrb[b]);
    end
  end

  // next-state, handshake and SRAM control
  always_comb begin
    state_nxt     = state;
    cpu_req_ready = 1'b0;
    cpu_rsp_valid = 1'b0;
    load_rsp      = 1'b0;
    rsp_data      = data_rd;
    l2_req_valid  = 1'b0;
    l2_req_we     = 1'b0;
    sram_en       = 1'b0;
    tag_we        = 1'b0;
    data_we       = 1'b0;
    sram_idx      = req_idx;
    data_wdata    = merged;
    accept        = 1'b0;
    do_flush      = 1'b0;
    refill        = 1'b0;
    case (state)
      IDLE: begin
        sram_idx = cpu_idx;
        // flush wins over a simultaneous request
        if (flush_i) begin
          do_flush = 1'b1;
        end else begin
          cpu_req_ready = 1'b1;
          if (cpu_req_valid) begin
            accept    = 1'b1;
            sram_en   = 1'b1;
            state_nxt = LOOKUP;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      LOOKUP: begin
        if (req_we) begin
          // only a hitting store updates the local copy
          if (hit) begin
            sram_en = 1'b1;
            data_we = 1'b1;
          end else begin
            sram_en = 1'b0;
          end
          state_nxt = WR_REQ;
        end else if (hit) begin
          cpu_rsp_valid = 1'b1;
          load_rsp      = 1'b1;
          state_nxt     = IDLE;
        end else begin
          state_nxt = MISS_REQ;
        end
      end
      MISS_REQ: begin
        l2_req_valid = 1'b1;
        if (l2_req_ready) begin
          state_nxt = MISS_WAIT;
        end else begin
          state_nxt = MISS_REQ;
        end
      end
      MISS_WAIT: begin
        if (l2_rsp_valid) begin
          sram_en       = 1'b1;
          tag_we        = 1'b1;
          data_we       = 1'b1;
          data_wdata    = l2_rsp_data;
          refill        = 1'b1;
          cpu_rsp_valid = 1'b1;
          load_rsp      = 1'b1;
          rsp_data      = l2_rsp_data;
          state_nxt     = IDLE;
        end else begin
          state_nxt = MISS_WAIT;
        end
      end
      WR_REQ: begin
        l2_req_valid = 1'b1;
        l2_req_we    = 1'b1;
        if (l2_req_ready) begin
          state_nxt = WR_WAIT;
        end else begin
          state_nxt = WR_REQ;
        end
      end
      WR_WAIT: begin
        if (l2_rsp_valid) begin
          cpu_rsp_valid = 1'b1;
          state_nxt     = IDLE;
        end else begin
          state_nxt = WR_WAIT;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // state register, request latch, valid bits and held load data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_wstrb  <= '0;
      valid      <= '0;
      rdata_hold <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_we    <= cpu_we;
        req_addr  <= cpu_addr & ALIGN_MASK;
        req_wdata <= cpu_wdata;
        req_wstrb <= cpu_wstrb;
      end
      if (do_flush) begin
        valid <= '0;
      end else if (refill) begin
        valid[req_idx] <= 1'b1;
      end
      if (load_rsp) begin
        rdata_hold <= rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_l1d_cache_dm.sv
// tb_l1d_cache_dm: directed, table-driven bench for l1d_cache_dm with a
// simple L2 responder; plus hand-written flush and mid-refill reset sequences.
module tb_l1d_cache_dm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req_valid = 1'b0;
  logic        cpu_req_ready;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [3:0]  cpu_wstrb = 4'h0;
  logic        flush_i = 1'b0;
  logic        cpu_rsp_valid;
  logic [31:0] cpu_rdata;
  logic        l2_req_valid;
  logic        l2_req_ready = 1'b0;
  logic        l2_req_we;
  logic [31:0] l2_req_addr;
  logic [31:0] l2_req_wdata;
  logic [3:0]  l2_req_wstrb;
  logic        l2_rsp_valid = 1'b0;
  logic [31:0] l2_rsp_data = 32'h0;

  always #5 clk = ~clk;

  l1d_cache_dm #(.ADDR_W(32), .DATA_W(32), .SET_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .flush_i(flush_i), .cpu_rsp_valid(cpu_rsp_valid), .cpu_rdata(cpu_rdata),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_we(l2_req_we),
    .l2_req_addr(l2_req_addr), .l2_req_wdata(l2_req_wdata), .l2_req_wstrb(l2_req_wstrb),
    .l2_rsp_valid(l2_rsp_valid), .l2_rsp_data(l2_rsp_data)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] l2_data;    // data the L2 model returns on a refill
    logic        exp_l2;     // an L2 request is expected
    logic [31:0] exp_rdata;  // expected load data
    int          stall;      // cycles l2_req_ready is held low
  } txn_t;

  txn_t        tbl[13];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_rdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "/req_ready"}, 32'(cpu_req_ready), 32'd1);
    chk({name, "/rsp_valid"}, 32'(cpu_rsp_valid), 32'd0);
    chk({name, "/rdata"}, cpu_rdata, 32'h0);
    chk({name, "/l2_outs"}, {25'd0, l2_req_valid, l2_req_we, l2_req_wstrb}, 32'd0);
    chk({name, "/l2_addr"}, l2_req_addr, 32'h0);
    chk({name, "/l2_wdata"}, l2_req_wdata, 32'h0);
  endtask

  // one request, serviced by the L2 model, with all checks on the way
  task automatic run_txn(input txn_t t, input string name);
    int          cyc, stalls, phase, rsp_cyc;
    bit          saw, done;
    logic [31:0] rd;
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_we        = t.we;
    cpu_addr      = t.addr;
    cpu_wdata     = t.wdata;
    cpu_wstrb     = t.wstrb;
    #1;
    chk({name, "/ready"}, 32'(cpu_req_ready), 32'd1);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cyc = 1; stalls = 0; phase = 0; rsp_cyc = 0; saw = 1'b0; done = 1'b0; rd = 32'h0;
    while (!done && cyc < 40) begin
      l2_req_ready = 1'b0;
      l2_rsp_valid = 1'b0;
      if (phase == 1) begin
        l2_rsp_valid = 1'b1;
        l2_rsp_data  = t.l2_data;
        phase        = 2;
      end
      #1;
      if (cpu_rsp_valid) begin
        done    = 1'b1;
        rsp_cyc = cyc;
        rd      = cpu_rdata;
      end else if (phase == 0 && l2_req_valid) begin
        if (!saw) begin
          saw = 1'b1;
          chk({name, "/l2_we"}, 32'(l2_req_we), 32'(t.we));
          chk({name, "/l2_addr"}, l2_req_addr, t.addr & 32'hFFFF_FFFC);
          if (t.we) begin
            chk({name, "/l2_wdata"}, l2_req_wdata, t.wdata);
            chk({name, "/l2_wstrb"}, 32'(l2_req_wstrb), 32'(t.wstrb));
          end
        end
        if (stalls < t.stall) begin
          stalls++;
          chk({name, "/stall_addr"}, l2_req_addr, t.addr & 32'hFFFF_FFFC);
          chk({name, "/stall_we"}, 32'(l2_req_we), 32'(t.we));
          chk({name, "/stall_ready"}, 32'(cpu_req_ready), 32'd0);
        end else begin
          l2_req_ready = 1'b1;
          phase        = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    l2_req_ready = 1'b0;
    l2_rsp_valid = 1'b0;
    chk({name, "/completed"}, 32'(done), 32'd1);
    chk({name, "/l2_seen"}, 32'(saw), 32'(t.exp_l2));
    if (!t.we) begin
      chk({name, "/rdata"}, rd, t.exp_rdata);
      last_rdata = t.exp_rdata;
      if (!t.exp_l2) begin
        chk({name, "/hit_latency"}, 32'(rsp_cyc), 32'd1);
      end
    end
    #1;
    chk({name, "/rsp_pulse"}, 32'(cpu_rsp_valid), 32'd0);
    chk({name, "/rdata_hold"}, cpu_rdata, last_rdata);
  endtask

  initial begin
    txn_t t;
    int   n;
    //         we    addr       wdata         strb  l2_data       l2    exp_rdata     stall
    tbl[0]  = '{1'b0, 32'h40,  32'h0,        4'h0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 0};
    tbl[1]  = '{1'b0, 32'h40,  32'h0,        4'h0, 32'h0,        1'b0, 32'hDEADBEEF, 0};
    tbl[2]  = '{1'b1, 32'h40,  32'h00001234, 4'h3, 32'h0,        1'b1, 32'h0,        2};
    tbl[3]  = '{1'b0, 32'h40,  32'h0,        4'h0, 32'h0,        1'b0, 32'hDEAD1234, 0};
    tbl[4]  = '{1'b1, 32'h80,  32'hCAFEF00D, 4'hF, 32'h0,        1'b1, 32'h0,        0};
    tbl[5]  = '{1'b0, 32'h80,  32'h0,        4'h0, 32'h11112222, 1'b1, 32'h11112222, 0};
    tbl[6]  = '{1'b1, 32'h80,  32'hAABBCCDD, 4'hC, 32'h0,        1'b1, 32'h0,        0};
    tbl[7]  = '{1'b0, 32'h80,  32'h0,        4'h0, 32'h0,        1'b0, 32'hAABB2222, 0};
    tbl[8]  = '{1'b0, 32'h140, 32'h0,        4'h0, 32'h55AA55AA, 1'b1, 32'h55AA55AA, 0};
    tbl[9]  = '{1'b0, 32'h140, 32'h0,        4'h0, 32'h0,        1'b0, 32'h55AA55AA, 0};
    tbl[10] = '{1'b0, 32'h40,  32'h0,        4'h0, 32'hDEAD1234, 1'b1, 32'hDEAD1234, 0};
    tbl[11] = '{1'b0, 32'h47,  32'h0,        4'h0, 32'h0BADF00D, 1'b1, 32'h0BADF00D, 5};
    tbl[12] = '{1'b0, 32'h44,  32'h0,        4'h0, 32'h0,        1'b0, 32'h0BADF00D, 0};

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_txn(tbl[i], $sformatf("v%0d", i));
    end

    // flush together with a request: flush taken, request not
    @(negedge clk);
    flush_i       = 1'b1;
    cpu_req_valid = 1'b1;
    cpu_we        = 1'b0;
    cpu_addr      = 32'h40;
    #1;
    chk("flush/req_ready", 32'(cpu_req_ready), 32'd0);
    @(negedge clk);
    flush_i       = 1'b0;
    cpu_req_valid = 1'b0;
    #1;
    chk("flush/no_rsp", 32'(cpu_rsp_valid), 32'd0);
    chk("flush/idle_ready", 32'(cpu_req_ready), 32'd1);
    t = '{1'b0, 32'h40, 32'h0, 4'h0, 32'hDEAD1234, 1'b1, 32'hDEAD1234, 0};
    run_txn(t, "flush_miss");

    // reset while waiting for refill data
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_we        = 1'b0;
    cpu_addr      = 32'h48;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    n = 0;
    #1;
    while (!l2_req_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rst/l2_req_seen", 32'(l2_req_valid), 32'd1);
    l2_req_ready = 1'b1;
    @(negedge clk);
    l2_req_ready = 1'b0;
    #1;
    chk("rst/l2_valid_drop", 32'(l2_req_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n      = 1'b1;
    last_rdata = 32'h0;
    t = '{1'b0, 32'h40, 32'h0, 4'h0, 32'hDEAD1234, 1'b1, 32'hDEAD1234, 0};
    run_txn(t, "rst_miss");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
